// File: rtl/board_move_engine.sv
// 4x4 sliding-tile game state: board register file, one-line-per-cycle move
// engine with merge scoring, win flag, and a combinational cell read port.
module board_move_engine #(
  parameter int WIN_EXP = 11,
  parameter int SCORE_W = 24
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iClear,
  input  logic               iStart,
  input  logic [1:0]         iDir,
  input  logic               iWrEn,
  input  logic [1:0]         iWrX,
  input  logic [1:0]         iWrY,
  input  logic [3:0]         iWrVal,
  input  logic [1:0]         iRdX,
  input  logic [1:0]         iRdY,
  output logic [3:0]         oRdVal,
  output logic               oBusy,
  output logic               oDone,
  output logic               oMoved,
  output logic               oWon,
  output logic [SCORE_W-1:0] oScore
);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_e;
  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_e;

  // Element [0] of a line is the cell at the destination edge.
  typedef logic [3:0][3:0] line_t;

  typedef struct packed {
    line_t       cells;
    logic [16:0] gain;
  } line_res_t;

  localparam logic [3:0] WIN_E = 4'(WIN_EXP);

  // Board index is {y, x}, so row y occupies cells 4y..4y+3.
  function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] k,
                                          input logic [1:0] i);
    logic [3:0] idx;
    case (dir)
      DIR_LEFT:  idx = {k, i};
      DIR_RIGHT: idx = {k, ~i};
      DIR_UP:    idx = {i, k};
      default:   idx = {~i, k};
    endcase
    return idx;
  endfunction

  function automatic line_t compress(input line_t l);
    line_t      r;
    logic [2:0] j;
    r = '0;
    j = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (l[i] != 4'd0) begin
        r[j[1:0]] = l[i];
        j = j + 3'd1;
      end
    end
    return r;
  endfunction

  // Compress, merge equal neighbours once each, compress again.
  function automatic line_res_t slide_line(input line_t l);
    line_res_t res;
    line_t     c;
    logic      skip;
    c        = compress(l);
    res.gain = '0;
    skip     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] == c[i+1] && c[i] != 4'd0 && c[i] != 4'hF) begin
        c[i]     = c[i] + 4'd1;
        c[i+1]   = 4'd0;
        res.gain = res.gain + (17'd1 << c[i]);
        skip     = 1'b1;
      end
    end
    res.cells = compress(c);
    return res;
  endfunction

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d;
  logic [1:0]           k_q, k_d;
  logic                 acc_q, acc_d;
  logic                 done_q, done_d;
  logic                 moved_q, moved_d;
  logic                 won_q, won_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [15:0][3:0]     board_q, board_d;

  logic [3:0]           line_idx [4];
  line_t                line_in;
  line_res_t            line_res;
  logic                 line_won;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      line_idx[i] = cell_idx(dir_q, k_q, 2'(i));
      line_in[i]  = board_q[line_idx[i]];
    end
  end

  assign line_res = slide_line(line_in);

  always_comb begin
    line_won = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (line_res.cells[i] >= WIN_E) line_won = 1'b1;
    end
  end

  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(line_res.gain);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    moved_d = moved_q;
    won_d   = won_q;
    score_d = score_q;
    board_d = board_q;

    case (state_q)
      S_IDLE: begin
        if (iClear) begin
          board_d = '0;
          score_d = '0;
          won_d   = 1'b0;
          moved_d = 1'b0;
        end else if (iStart) begin
          dir_d   = dir_e'(iDir);
          k_d     = 2'd0;
          acc_d   = 1'b0;
          state_d = S_PROC;
        end else if (iWrEn) begin
          board_d[{iWrY, iWrX}] = iWrVal;
          if (iWrVal >= WIN_E) won_d = 1'b1;
        end
      end
      S_PROC: begin
        for (int i = 0; i < 4; i++) begin
          board_d[line_idx[i]] = line_res.cells[i];
        end
        if (line_res.cells != line_in) acc_d = 1'b1;
        if (line_won) won_d = 1'b1;
        score_d = score_sat;
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        moved_d = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the board is a flop-based register file, so it takes the async reset
  // like every other state bit; a reset mid-move leaves nothing behind.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_LEFT;
      k_q     <= 2'd0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      moved_q <= 1'b0;
      won_q   <= 1'b0;
      score_q <= '0;
      board_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      moved_q <= moved_d;
      won_q   <= won_d;
      score_q <= score_d;
      board_q <= board_d;
    end
  end

  assign oRdVal = board_q[{iRdY, iRdX}];
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = done_q;
  assign oMoved = moved_q;
  assign oWon   = won_q;
  assign oScore = score_q;

endmodule
